// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//
// Main decoder plus ALU-control decoder for an RV32I single-cycle datapath.
// Every control output is registered, so a decode appears on the outputs one
// rising edge after its instruction fields were presented. No combinational
// input-to-output path exists.
//
// Ports
//   clk        : system clock, all outputs update on the rising edge
//   rst        : synchronous, active-high reset (clears every output)
//   opcode     : instr[6:0]
//   funct3     : instr[14:12]
//   funct7     : instr[31:25], only bit 5 is used
//   reg_write  : write rd in the register file
//   mem_read   : data-memory read enable
//   mem_write  : data-memory write enable
//   mem_to_reg : writeback select, 1 = memory data, 0 = ALU result
//   branch     : instruction is a conditional branch
//   alu_src    : ALU operand B, 1 = immediate, 0 = rs2
//   alu_ctl    : 4-bit ALU operation code
// -----------------------------------------------------------------------------
module control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       branch,
  output logic       alu_src,
  output logic [3:0] alu_ctl
);

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_SRA  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_e;

  typedef enum logic [6:0] {
    OP_R_TYPE = 7'b0110011,
    OP_I_ALU  = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011
  } opcode_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    branch;
    logic    alu_src;
    alu_op_e alu_ctl;
  } ctl_t;

  localparam ctl_t CTL_NOP = '{
    reg_write:  1'b0,
    mem_read:   1'b0,
    mem_write:  1'b0,
    mem_to_reg: 1'b0,
    branch:     1'b0,
    alu_src:    1'b0,
    alu_ctl:    ALU_AND
  };

  ctl_t ctl_d;
  ctl_t ctl_q;

  // Shared funct3 map for R-type and I-type ALU ops. 'sub_ok' is only set for
  // R-type: ADDI has no subtract form, so funct7[5] must not turn it into SUB.
  // The shift-right alternate (SRA/SRAI) is selected by funct7[5] for both.
  function automatic alu_op_e alu_from_funct3(input logic [2:0] f3,
                                              input logic       alt,
                                              input logic       sub_ok);
    alu_op_e op;
    op = ALU_ADD;
    unique case (f3)
      3'b000:  op = (alt && sub_ok) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // Branches compare with the ALU: equality via SUB, signed and unsigned
  // ordering via SLT/SLTU. The reserved funct3 values 010/011 fall back to SUB.
  function automatic alu_op_e alu_for_branch(input logic [2:0] f3);
    alu_op_e op;
    op = ALU_SUB;
    case (f3[2:1])
      2'b10:   op = ALU_SLT;
      2'b11:   op = ALU_SLTU;
      default: op = ALU_SUB;
    endcase
    return op;
  endfunction

  always_comb begin
    // NOTE: ctl_d is given a full default before the case so that no path
    // leaves it unassigned; a missing default here would infer a latch.
    ctl_d = CTL_NOP;
    case (opcode)
      OP_R_TYPE: begin
        ctl_d.reg_write = 1'b1;
        ctl_d.alu_ctl   = alu_from_funct3(funct3, funct7[5], 1'b1);
      end
      OP_I_ALU: begin
        ctl_d.reg_write = 1'b1;
        ctl_d.alu_src   = 1'b1;
        ctl_d.alu_ctl   = alu_from_funct3(funct3, funct7[5], 1'b0);
      end
      OP_LOAD: begin
        ctl_d.reg_write  = 1'b1;
        ctl_d.mem_read   = 1'b1;
        ctl_d.mem_to_reg = 1'b1;
        ctl_d.alu_src    = 1'b1;
        ctl_d.alu_ctl    = ALU_ADD;
      end
      OP_STORE: begin
        ctl_d.mem_write = 1'b1;
        ctl_d.alu_src   = 1'b1;
        ctl_d.alu_ctl   = ALU_ADD;
      end
      OP_BRANCH: begin
        ctl_d.branch  = 1'b1;
        ctl_d.alu_ctl = alu_for_branch(funct3);
      end
      // Unsupported opcodes stay at the NOP default: no register or memory
      // side effects.
      default: ctl_d = CTL_NOP;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // its inputs from before the edge, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctl_q <= CTL_NOP;
    end else begin
      ctl_q <= ctl_d;
    end
  end

  assign reg_write  = ctl_q.reg_write;
  assign mem_read   = ctl_q.mem_read;
  assign mem_write  = ctl_q.mem_write;
  assign mem_to_reg = ctl_q.mem_to_reg;
  assign branch     = ctl_q.branch;
  assign alu_src    = ctl_q.alu_src;
  assign alu_ctl    = ctl_q.alu_ctl;

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
//
// Directed bench for control_unit. Each step presents one instruction word,
// waits for the rising edge, then compares the registered outputs 1 ns later
// against a hand-computed 10-bit vector:
//   {reg_write, mem_read, mem_write, mem_to_reg, branch, alu_src, alu_ctl[3:0]}
// -----------------------------------------------------------------------------
module tb_control_unit;

  logic       clk;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic       mem_to_reg;
  logic       branch;
  logic       alu_src;
  logic [3:0] alu_ctl;

  int n_checks = 0;
  int n_pass   = 0;

  control_unit dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7     (funct7),
    .reg_write  (reg_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_to_reg (mem_to_reg),
    .branch     (branch),
    .alu_src    (alu_src),
    .alu_ctl    (alu_ctl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected-vector field groups: flags are rw/mr/mw/mtr/br/as.
  localparam logic [5:0] F_R     = 6'b100000;
  localparam logic [5:0] F_I     = 6'b100001;
  localparam logic [5:0] F_LOAD  = 6'b110101;
  localparam logic [5:0] F_STORE = 6'b001001;
  localparam logic [5:0] F_BR    = 6'b000010;
  localparam logic [5:0] F_NONE  = 6'b000000;

  task automatic check(input string tag, input logic [9:0] exp);
    logic [9:0] obs;
    obs = {reg_write, mem_read, mem_write, mem_to_reg, branch, alu_src, alu_ctl};
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic set_instr(input logic [31:0] instr);
    opcode = instr[6:0];
    funct3 = instr[14:12];
    funct7 = instr[31:25];
  endtask

  // Present an instruction, clock once, check the decode one edge later.
  task automatic step(input string tag, input logic [31:0] instr,
                      input logic [5:0] flags, input logic [3:0] alu);
    set_instr(instr);
    @(posedge clk);
    #1;
    check(tag, {flags, alu});
  endtask

  initial begin
    rst = 1'b1;
    set_instr(32'h0000_0033);

    // Reset held for two edges with an R-type ADD on the inputs.
    @(posedge clk); #1; check("reset_edge1", {F_NONE, 4'b0000});
    @(posedge clk); #1; check("reset_edge2", {F_NONE, 4'b0000});

    // First edge after release decodes the ADD already on the inputs.
    rst = 1'b0;
    step("r_add_after_reset", 32'h0000_0033, F_R, 4'b0010);

    // R-type funct3/funct7 sweep.
    step("r_sub",  32'h4000_0033, F_R, 4'b0110);
    step("r_sll",  32'h0000_1033, F_R, 4'b0100);
    step("r_slt",  32'h0000_2033, F_R, 4'b0111);
    step("r_sltu", 32'h0000_3033, F_R, 4'b1001);
    step("r_xor",  32'h0000_4033, F_R, 4'b0011);
    step("r_srl",  32'h0000_5033, F_R, 4'b0101);
    step("r_sra",  32'h4000_5033, F_R, 4'b1000);
    step("r_or",   32'h0000_6033, F_R, 4'b0001);
    step("r_and",  32'h0000_7033, F_R, 4'b0000);
    // Only funct7[5] matters: other bits set must not change ADD.
    step("r_add_f7_junk", 32'hBE00_0033, F_R, 4'b0010);

    // Outputs hold between edges even when inputs change.
    set_instr(32'h0000_2023);
    #3;
    check("hold_between_edges", {F_R, 4'b0010});

    // Load / store.
    step("lw", 32'h0000_2003, F_LOAD,  4'b0010);
    step("sw", 32'h0000_2023, F_STORE, 4'b0010);

    // Branches.
    step("beq",  32'h0000_0063, F_BR, 4'b0110);
    step("bne",  32'h0000_1063, F_BR, 4'b0110);
    step("br_f3_010", 32'h0000_2063, F_BR, 4'b0110);
    step("blt",  32'h0000_4063, F_BR, 4'b0111);
    step("bge",  32'h0000_5063, F_BR, 4'b0111);
    step("bltu", 32'h0000_6063, F_BR, 4'b1001);
    step("bgeu", 32'h0000_7063, F_BR, 4'b1001);

    // I-type ALU: no SUBI, SRAI via funct7[5].
    step("addi",       32'h0000_0013, F_I, 4'b0010);
    step("addi_f7_20", 32'h4000_0013, F_I, 4'b0010);
    step("srli",       32'h0000_5013, F_I, 4'b0101);
    step("srai",       32'h4000_5013, F_I, 4'b1000);
    step("xori",       32'h0000_4013, F_I, 4'b0011);
    step("sltiu",      32'h0000_3013, F_I, 4'b1001);

    // Illegal / unsupported opcodes decode to a NOP.
    step("illegal_7f", 32'hFFFF_FFFF, F_NONE, 4'b0000);
    step("lui_unsup",  32'h0000_0037, F_NONE, 4'b0000);

    // Back-to-back decodes, each exactly one edge after its input.
    step("b2b_lw",  32'h0000_2003, F_LOAD,  4'b0010);
    step("b2b_sw",  32'h0000_2023, F_STORE, 4'b0010);
    step("b2b_beq", 32'h0000_0063, F_BR,    4'b0110);

    // Mid-stream reset discards the in-flight decode.
    rst = 1'b1;
    step("mid_reset_lw", 32'h0000_2003, F_NONE, 4'b0000);
    rst = 1'b0;
    step("after_mid_reset_lw", 32'h0000_2003, F_LOAD, 4'b0010);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
